// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding, default width and counter sizing helper.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // 2'd3 is unused and falls back to IDLE in the FSM default branch.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder slice used by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, registered carry.
// Result and carry-out are registered on the last bit and held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             load, step, last;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (c_reg),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // Full result including the bit produced on the current edge.
  assign res_next = {fa_s, res_sr};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      c_reg  <= cin;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next[WIDTH-1:1];
      c_reg  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum  <= res_next;
        cout <= fa_c;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, scoreboard and corner sequences,
// plus an exhaustive sweep of a 4-bit instance.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion of the 8-bit DUT pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got 0x%0h expected none", {cout8, sum8});
      end else begin
        check("sb_result", {23'd0, cout8, sum8}, {23'd0, exp_q.pop_front()});
      end
      check("done_single", {31'd0, prev_done}, 32'd0);
    end
    prev_done = done8;
  end

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input bit push);
    a8     = a;
    b8     = b;
    cin8   = cin;
    start8 = 1'b1;
    if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
  endtask

  task automatic wait_done(input int glitch, output int cyc, output int nbusy);
    logic [8:0] held;
    int drift;
    held  = {cout8, sum8};
    cyc   = 0;
    nbusy = 0;
    drift = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
      end
      if (glitch > 0 && cyc == glitch) begin
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'h55;
        cin8   = 1'b0;
      end
      if (glitch > 0 && cyc == glitch + 1) start8 = 1'b0;
      if (busy8) nbusy++;
      if (!done8 && {cout8, sum8} !== held) drift++;
    end while (!done8 && cyc < 64);
    check("done_timeout", {31'd0, done8}, 32'd1);
    check("sum_held", drift, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int cyc, nb, d0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst_n  = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    cin8   = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    cin4   = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_sum", {24'd0, sum8}, 0);
    check("rst_cout", {31'd0, cout8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      wait_done(0, cyc, nb);
      check("vec_sum", {24'd0, sum8}, {24'd0, vecs[i].sum});
      check("vec_cout", {31'd0, cout8}, {31'd0, vecs[i].cout});
      check("vec_latency", cyc, 9);
      check("vec_busy_len", nb, 8);
      @(negedge clk);
      check("vec_done_drop", {31'd0, done8}, 0);
      check("vec_idle", {31'd0, busy8}, 0);
    end

    // A start pulse during RUN must be ignored.
    @(negedge clk);
    d0 = done_seen;
    launch(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(3, cyc, nb);
    check("glitch_sum", {24'd0, sum8}, 32'h30);
    check("glitch_cout", {31'd0, cout8}, 0);
    check("glitch_busy_len", nb, 8);
    repeat (12) @(negedge clk);
    check("glitch_single_done", done_seen - d0, 1);

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    launch(8'h5A, 8'h3C, 1'b0, 1'b1);
    wait_done(0, cyc, nb);
    check("b2b_first", {24'd0, sum8}, 32'h96);
    launch(8'h01, 8'h01, 1'b0, 1'b1);
    wait_done(0, cyc, nb);
    check("b2b_gap", cyc, 9);
    check("b2b_busy_len", nb, 8);
    check("b2b_second", {24'd0, sum8}, 32'h02);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    d0 = done_seen;
    launch(8'h77, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy8}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy8}, 0);
    check("arst_done", {31'd0, done8}, 0);
    check("arst_sum", {24'd0, sum8}, 0);
    check("arst_cout", {31'd0, cout8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_done", done_seen - d0, 0);
    launch(8'h0F, 8'h01, 1'b0, 1'b1);
    wait_done(0, cyc, nb);
    check("post_rst_sum", {24'd0, sum8}, 32'h10);

    // Exhaustive sweep of the 4-bit instance.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          int n;
          @(negedge clk);
          a4     = 4'(ai);
          b4     = 4'(bi);
          cin4   = 1'(ci);
          start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          a4     = 4'($urandom);
          b4     = 4'($urandom);
          n = 0;
          while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
          end
          if (!done4) begin
            check("w4_timeout", {31'd0, done4}, 1);
          end else begin
            check("w4_result", {27'd0, cout4, sum4}, ai + bi + ci);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
